// File: rtl/memory_access_unit.sv
// memory_access_unit: memory-stage data-memory controller.
// Converts a load/store in M into a registered req/ready bus transaction with
// byte enables, stalls the pipeline until the transaction completes, and
// presents the aligned, extended load word on ReadData_M during DONE.
// Optional feature macro: DMEM_MISALIGN_EXC_EN (misaligned-access trap and
// Misaligned_M port). Without it, offending low address bits are ignored.
module memory_access_unit #(
  parameter int unsigned WIDTH_32 = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemRead_M,
  input  logic                MemWrite_M,
  input  logic [1:0]          ByteControl_M,
  input  logic                LoadUnsigned_M,
  input  logic [WIDTH_32-1:0] ALU_result_M,
  input  logic [WIDTH_32-1:0] WriteData_M,
  output logic [WIDTH_32-1:0] ReadData_M,
  output logic                Stall_M,
  output logic                BusErr_M,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WIDTH_32-1:0] dmem_addr,
  output logic [WIDTH_32-1:0] dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ready,
  input  logic [WIDTH_32-1:0] dmem_rdata
`ifdef DMEM_MISALIGN_EXC_EN
  ,
  output logic                Misaligned_M
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic [WIDTH_32-1:0] load_buf;
  logic [1:0]          lane_q;
  logic [1:0]          bc_q;
  logic                uns_q;
  logic                err_q;

  logic                access;
  logic                trap;
  logic [3:0]          be_n;
  logic [WIDTH_32-1:0] wdata_n;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [WIDTH_32-1:0] fmt_data;

  assign access = MemRead_M | MemWrite_M;

`ifdef DMEM_MISALIGN_EXC_EN
  logic mis;

  // Misalignment: halfword on odd address, word on any non-zero low bits
  always_comb begin
    mis = 1'b0;
    case (ByteControl_M)
      2'b01:   mis = ALU_result_M[0];
      2'b10:   mis = 1'b0;
      default: mis = |ALU_result_M[1:0];
    endcase
  end

  assign trap         = (state == IDLE) & access & mis;
  assign Misaligned_M = trap;
`else
  assign trap = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the incoming access
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = WriteData_M;
    case (ByteControl_M)
      2'b01: begin
        be_n    = ALU_result_M[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{WriteData_M[15:0]}};
      end
      2'b10: begin
        be_n    = 4'b0001 << ALU_result_M[1:0];
        wdata_n = {4{WriteData_M[7:0]}};
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered bus outputs, load buffer and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_buf   <= '0;
      cnt        <= '0;
      lane_q     <= '0;
      bc_q       <= '0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !trap) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_M;
            dmem_addr  <= {ALU_result_M[WIDTH_32-1:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_be    <= be_n;
            lane_q     <= ALU_result_M[1:0];
            bc_q       <= ByteControl_M;
            uns_q      <= LoadUnsigned_M;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // ready is tested first so it wins over a same-cycle timeout
          if (dmem_ready) begin
            if (!dmem_we) load_buf <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            dmem_req <= 1'b0;
            load_buf <= '0;
            err_q    <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane selection and sign/zero extension of the load buffer
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = load_buf[7:0];
      2'd1:    byte_sel = load_buf[15:8];
      2'd2:    byte_sel = load_buf[23:16];
      default: byte_sel = load_buf[31:24];
    endcase
    half_sel = lane_q[1] ? load_buf[31:16] : load_buf[15:0];
    case (bc_q)
      2'b01:   fmt_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      2'b10:   fmt_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      default: fmt_data = load_buf;
    endcase
  end

  assign ReadData_M = (state == DONE) ? fmt_data : '0;
  assign Stall_M    = ((state == IDLE) & access & ~trap) | (state == BUSY);
  assign BusErr_M   = err_q & (state == DONE);

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage data-memory controller of the pipelined MIPS core. Sits between the EX/MEM pipeline register and the Memory_WriteBack_Register. Turns a load/store in M into a registered request/ready bus transaction with byte enables, and stalls the pipeline until the transaction completes. Presents the aligned, sign/zero-extended load word as `ReadData_M` to the MEM/WB register.

## Interface
- `WIDTH_32`, 32: address/data width.
- `TIMEOUT`, 255: maximum BUSY cycles without `dmem_ready` before the access is aborted (1..255).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead_M` in 1: load in M.
- `MemWrite_M` in 1: store in M; never set together with `MemRead_M`.
- `ByteControl_M` in 2: 00 word, 01 halfword, 10 byte, 11 treated as word.
- `LoadUnsigned_M` in 1: 1 = zero-extend, 0 = sign-extend sub-word loads.
- `ALU_result_M` in 32: byte address.
- `WriteData_M` in 32: store data, right-justified.
- `ReadData_M` out 32: formatted load data; to MEM/WB.
- `Stall_M` out 1: to hazard unit; drives EN low / stalls F, D, E, M registers.
- `BusErr_M` out 1: access aborted by timeout; valid in DONE only.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (bits[1:0]=0), `dmem_wdata` out 32, `dmem_be` out 4: registered bus request.
- `dmem_ready` in 1, `dmem_rdata` in 32: bus response, sampled while `dmem_req`=1.
- `Misaligned_M` out 1: present only with `DMEM_MISALIGN_EXC_EN`.

## Operation
- access = `MemRead_M` | `MemWrite_M`. States IDLE, BUSY, DONE.
- IDLE: if access (and not trapped misaligned), on the next edge latch addr/we/be/wdata, set `dmem_req`=1, clear timeout counter, go BUSY. Otherwise stay IDLE.
- BUSY: hold all bus outputs stable. On an edge with `dmem_ready`=1, capture `dmem_rdata` into the load buffer (loads only), clear `dmem_req`, go DONE. If the counter reaches `TIMEOUT` first, clear `dmem_req`, zero the buffer, set the error flag, go DONE. Otherwise increment the counter.
- DONE: one cycle, unconditionally, then IDLE. A new access is never issued from DONE.
- `Stall_M` = (IDLE & access & !trap) | BUSY. It is combinational and 0 in DONE, so the pipeline advances exactly at the DONE edge.
- Lanes are little-endian. lane = latched addr[1:0].
  - Byte store: data[7:0] replicated to all 4 lanes, be = 1<<lane.
  - Half store: data[15:0] replicated, be = 0011 (addr[1]=0) or 1100.
  - Word store: be = 1111.
- Load formatting in DONE:
  - Byte: buffer byte at lane.
  - Half: buffer half at addr[1].
  - Word: whole buffer.
  - Sub-word results are extended per the latched `LoadUnsigned_M`.
- `ReadData_M` = formatted buffer in DONE, else 0.
- `BusErr_M` = error flag & DONE. The flag clears on entering IDLE.
- Reset mid-operation: `dmem_req` drops immediately and the FSM returns to IDLE. No bus completion is awaited.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `BusErr_M`, `ReadData_M` = 0.
  - `dmem_addr`, `dmem_wdata`, `dmem_be` = 0.
  - Buffer and counter = 0.
- Minimum access: 3 cycles (IDLE issue, BUSY with ready, DONE). Each extra wait cycle adds 1.
- `dmem_ready` while `dmem_req`=0 is ignored.
- Back-to-back accesses: DONE → IDLE → issue. Each access therefore costs at least 3 cycles, with no bubble beyond DONE.
- Ready in the same cycle the counter hits `TIMEOUT`: ready wins, and there is no error.

## Configuration
- `DMEM_MISALIGN_EXC_EN` defined:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) in IDLE asserts `Misaligned_M`=1 combinationally.
  - No request is issued, `Stall_M`=0, and `ReadData_M`=0.
- Not defined:
  - `Misaligned_M` port is absent.
  - Offending low address bits are ignored: word forces lane 0, half uses addr[1] only.

## Test plan
- Reset asserted during BUSY → `dmem_req` falls asynchronously, and after release the FSM is IDLE with all outputs 0.
- Word load at 0x100, ready on the first BUSY cycle, rdata=0xDEADBEEF → `Stall_M` high for 2 cycles, `ReadData_M`=0xDEADBEEF in DONE, `dmem_be`=1111.
- Byte load at 0x103, rdata=0x80000000, signed → 0xFFFFFF80. With `LoadUnsigned_M`=1 → 0x00000080.
- Half store 0xABCD at 0x202, ready after 4 wait cycles → `dmem_wdata`=0xABCDABCD, `dmem_be`=1100, `dmem_we`=1, and `Stall_M` high for 6 cycles.
- `TIMEOUT`=4, ready never asserted → after 4 BUSY cycles: DONE with `BusErr_M`=1, `ReadData_M`=0, `dmem_req`=0.
- Word load at 0x101 → with macro: `Misaligned_M`=1, no `dmem_req`, `Stall_M`=0. Without macro: `dmem_addr`=0x100.
